// File: rtl/cmp_seq_ctrl.sv
// cmp_seq_ctrl: sequences a 16-bit compare MSB-nibble-first through one
// external 4-bit eq/gt/lt comparator slice and evaluates the branch condition.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | ready for a request, slice inputs parked at zero
// RUN    | one nibble per cycle presented to the slice, idx 3 down to 0
// DONE   | result held on resp_*, waiting for resp_ready
module cmp_seq_ctrl #(
  parameter logic EARLY_EXIT = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [15:0] rs1_reg,
  input  logic [15:0] rs2_reg,
  input  logic [2:0]  func,
  output logic [3:0]  slc_a,
  output logic [3:0]  slc_b,
  input  logic        slc_eq,
  input  logic        slc_gt,
  input  logic        slc_lt,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic        eq,
  output logic        gt,
  output logic        lt,
  output logic        taken,
  output logic        err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]  r_state;
  logic [1:0]  r_idx;
  logic [15:0] r_a;
  logic [15:0] r_b;
  logic [2:0]  r_func;
  logic        r_dec;
  logic        r_dgt;
  logic        r_dlt;
  logic        r_eq;
  logic        r_gt;
  logic        r_lt;
  logic        r_taken;
  logic        r_err;

  logic        w_run;
  logic        w_signed;
  logic        w_rsvd;
  logic [3:0]  w_flip;
  logic [3:0]  w_nib_a;
  logic [3:0]  w_nib_b;
  logic        w_hit;
  logic        w_decisive;
  logic        w_gt;
  logic        w_lt;
  logic        w_eq;
  logic        w_taken;

  assign w_run    = (r_state == S_RUN);
  assign w_signed = (r_func[2:1] == 2'b10);
  assign w_rsvd   = (r_func[2:1] == 2'b01);

  // Flipping the sign bit of the top nibble maps two's-complement order
  // onto unsigned order, so the same unsigned slice serves both.
  assign w_flip  = (w_signed && (r_idx == 2'd3)) ? 4'b1000 : 4'b0000;
  assign w_nib_a = r_a[{r_idx, 2'b00} +: 4];
  assign w_nib_b = r_b[{r_idx, 2'b00} +: 4];
  assign slc_a   = w_run ? (w_nib_a ^ w_flip) : 4'h0;
  assign slc_b   = w_run ? (w_nib_b ^ w_flip) : 4'h0;

  // slc_eq is implied by neither gt nor lt; eq is derived so exactly one
  // of eq/gt/lt is ever reported.
  assign w_hit      = slc_gt | slc_lt;
  assign w_decisive = (EARLY_EXIT & w_hit) | (r_idx == 2'd0);
  assign w_gt       = r_dec ? r_dgt : slc_gt;
  assign w_lt       = r_dec ? r_dlt : slc_lt;
  assign w_eq       = ~(w_gt | w_lt);

  // Branch condition from the final compare result of this cycle.
  always_comb begin
    w_taken = 1'b0;
    case (r_func)
      3'b000:  w_taken = w_eq;
      3'b001:  w_taken = ~w_eq;
      3'b100:  w_taken = w_lt;
      3'b101:  w_taken = ~w_lt;
      3'b110:  w_taken = w_lt;
      3'b111:  w_taken = ~w_lt;
      default: w_taken = 1'b0;
    endcase
  end

  // Controller state, operand capture, nibble scan and result registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_idx   <= 2'd3;
      r_a     <= 16'h0000;
      r_b     <= 16'h0000;
      r_func  <= 3'b000;
      r_dec   <= 1'b0;
      r_dgt   <= 1'b0;
      r_dlt   <= 1'b0;
      r_eq    <= 1'b0;
      r_gt    <= 1'b0;
      r_lt    <= 1'b0;
      r_taken <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_a     <= rs1_reg;
            r_b     <= rs2_reg;
            r_func  <= func;
            r_idx   <= 2'd3;
            r_dec   <= 1'b0;
            r_dgt   <= 1'b0;
            r_dlt   <= 1'b0;
            r_eq    <= 1'b0;
            r_gt    <= 1'b0;
            r_lt    <= 1'b0;
            r_taken <= 1'b0;
            r_err   <= 1'b0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          if (w_decisive) begin
            r_eq    <= w_eq;
            r_gt    <= w_gt;
            r_lt    <= w_lt;
            r_taken <= w_taken;
            r_err   <= w_rsvd;
            r_state <= S_DONE;
          end else begin
            r_idx <= r_idx - 2'd1;
            // Fixed-latency mode: the most significant differing nibble wins.
            if (!r_dec && w_hit) begin
              r_dec <= 1'b1;
              r_dgt <= slc_gt;
              r_dlt <= slc_lt;
            end
          end
        end
        S_DONE: begin
          if (resp_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_ready  = (r_state == S_IDLE);
  assign resp_valid = (r_state == S_DONE);
  assign eq         = r_eq;
  assign gt         = r_gt;
  assign lt         = r_lt;
  assign taken      = r_taken;
  assign err        = r_err;

endmodule

// File: tb/tb_cmp_seq_ctrl.sv
// Bench for cmp_seq_ctrl: one early-exit instance and one fixed-latency
// instance, each with its own behavioural 4-bit comparator slice.
module tb_cmp_seq_ctrl;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        resp_ready;
  logic [15:0] rs1;
  logic [15:0] rs2;
  logic [2:0]  func;
  logic        sel;

  logic        rv1, rv0;
  logic        rr1, rr0;
  logic [3:0]  sa1, sb1, sa0, sb0;
  logic        s1_eq, s1_gt, s1_lt, s0_eq, s0_gt, s0_lt;
  logic        pv1, pv0;
  logic        eq1, gt1, lt1, tk1, er1;
  logic        eq0, gt0, lt0, tk0, er0;

  logic        c_req_ready, c_resp_valid, c_eq, c_gt, c_lt, c_tk, c_err;
  logic [3:0]  c_sa, c_sb;

  int          n_checks;
  int          n_fail;

  int          lat;
  logic [15:0] seq_a;
  logic [15:0] seq_b;

  assign rv1 = req_valid & ~sel;
  assign rv0 = req_valid & sel;

  assign s1_eq = (sa1 == sb1);
  assign s1_gt = (sa1 >  sb1);
  assign s1_lt = (sa1 <  sb1);
  assign s0_eq = (sa0 == sb0);
  assign s0_gt = (sa0 >  sb0);
  assign s0_lt = (sa0 <  sb0);

  assign c_req_ready  = sel ? rr0 : rr1;
  assign c_resp_valid = sel ? pv0 : pv1;
  assign c_eq         = sel ? eq0 : eq1;
  assign c_gt         = sel ? gt0 : gt1;
  assign c_lt         = sel ? lt0 : lt1;
  assign c_tk         = sel ? tk0 : tk1;
  assign c_err        = sel ? er0 : er1;
  assign c_sa         = sel ? sa0 : sa1;
  assign c_sb         = sel ? sb0 : sb1;

  cmp_seq_ctrl #(.EARLY_EXIT(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(rv1), .req_ready(rr1),
    .rs1_reg(rs1), .rs2_reg(rs2), .func(func),
    .slc_a(sa1), .slc_b(sb1), .slc_eq(s1_eq), .slc_gt(s1_gt), .slc_lt(s1_lt),
    .resp_valid(pv1), .resp_ready(resp_ready),
    .eq(eq1), .gt(gt1), .lt(lt1), .taken(tk1), .err(er1)
  );

  cmp_seq_ctrl #(.EARLY_EXIT(1'b0)) dut_fixed (
    .clk(clk), .rst_n(rst_n), .req_valid(rv0), .req_ready(rr0),
    .rs1_reg(rs1), .rs2_reg(rs2), .func(func),
    .slc_a(sa0), .slc_b(sb0), .slc_eq(s0_eq), .slc_gt(s0_gt), .slc_lt(s0_lt),
    .resp_valid(pv0), .resp_ready(resp_ready),
    .eq(eq0), .gt(gt0), .lt(lt0), .taken(tk0), .err(er0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        sel;
    logic [15:0] a;
    logic [15:0] b;
    logic [2:0]  f;
    logic        e_eq;
    logic        e_gt;
    logic        e_lt;
    logic        e_tk;
    logic        e_err;
    int          e_lat;
    logic [15:0] e_sa;
    logic [15:0] e_sb;
  } vec_t;

  vec_t vecs[15];

  function automatic vec_t mk(input logic s, input logic [15:0] a, input logic [15:0] b,
                              input logic [2:0] f, input logic e_eq, input logic e_gt,
                              input logic e_lt, input logic e_tk, input logic e_err,
                              input int e_lat, input logic [15:0] e_sa, input logic [15:0] e_sb);
    vec_t v;
    v.sel = s; v.a = a; v.b = b; v.f = f;
    v.e_eq = e_eq; v.e_gt = e_gt; v.e_lt = e_lt; v.e_tk = e_tk; v.e_err = e_err;
    v.e_lat = e_lat; v.e_sa = e_sa; v.e_sb = e_sb;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!c_req_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!c_req_ready) chk("req_ready_timeout", 32'(c_req_ready), 32'd1);
  endtask

  // Called 1 time unit after the accept edge; counts the accept cycle as 1.
  task automatic wait_resp();
    lat   = 1;
    seq_a = 16'h0;
    seq_b = 16'h0;
    while (!c_resp_valid && lat < 20) begin
      seq_a = {seq_a[11:0], c_sa};
      seq_b = {seq_b[11:0], c_sb};
      @(posedge clk); #1;
      lat++;
    end
    if (!c_resp_valid) chk("resp_valid_timeout", 32'(c_resp_valid), 32'd1);
  endtask

  task automatic issue(input logic s, input logic [15:0] a, input logic [15:0] b,
                       input logic [2:0] f, input logic rr);
    sel        = s;
    resp_ready = rr;
    wait_ready();
    rs1       = a;
    rs2       = b;
    func      = f;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    wait_resp();
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    sel        = 1'b0;
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    rs1        = 16'h0;
    rs2        = 16'h0;
    func       = 3'b000;

    //                  sel a        b        f       eq    gt    lt    tk    err  lat sa       sb
    vecs[0]  = mk(1'b0, 16'h8000, 16'h0001, 3'b100, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2, 16'h0000, 16'h0008);
    vecs[1]  = mk(1'b0, 16'h8000, 16'h0001, 3'b110, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2, 16'h0008, 16'h0000);
    vecs[2]  = mk(1'b0, 16'h1234, 16'h1234, 3'b000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5, 16'h1234, 16'h1234);
    vecs[3]  = mk(1'b0, 16'h1234, 16'h1234, 3'b001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5, 16'h1234, 16'h1234);
    vecs[4]  = mk(1'b0, 16'h12A4, 16'h1294, 3'b111, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4, 16'h012A, 16'h0129);
    vecs[5]  = mk(1'b0, 16'hFFFF, 16'hFFFE, 3'b100, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5, 16'h7FFF, 16'h7FFE);
    vecs[6]  = mk(1'b0, 16'h0005, 16'h0003, 3'b010, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 5, 16'h0005, 16'h0003);
    vecs[7]  = mk(1'b0, 16'h7FFF, 16'h8000, 3'b101, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2, 16'h000F, 16'h0000);
    vecs[8]  = mk(1'b0, 16'h0100, 16'h0200, 3'b110, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3, 16'h0001, 16'h0002);
    vecs[9]  = mk(1'b0, 16'h0030, 16'h0020, 3'b011, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4, 16'h0003, 16'h0002);
    vecs[10] = mk(1'b0, 16'hFFFE, 16'hFFFF, 3'b111, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5, 16'hFFFE, 16'hFFFF);
    vecs[11] = mk(1'b0, 16'h8000, 16'h8000, 3'b100, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5, 16'h0000, 16'h0000);
    vecs[12] = mk(1'b1, 16'h12A4, 16'h1294, 3'b111, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 5, 16'h12A4, 16'h1294);
    vecs[13] = mk(1'b1, 16'h8000, 16'h0001, 3'b100, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5, 16'h0000, 16'h8001);
    vecs[14] = mk(1'b1, 16'h0005, 16'h0003, 3'b010, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 5, 16'h0005, 16'h0003);

    // Reset state
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_req_ready",  32'(rr1), 32'd1);
    chk("rst_resp_valid", 32'(pv1), 32'd0);
    chk("rst_flags",      32'({eq1, gt1, lt1, tk1, er1}), 32'd0);
    chk("rst_slc",        32'({sa1, sb1}), 32'd0);
    chk("rst_fixed_ready", 32'(rr0), 32'd1);
    rst_n = 1'b1;

    // Table-driven compares
    for (int i = 0; i < 15; i++) begin
      issue(vecs[i].sel, vecs[i].a, vecs[i].b, vecs[i].f, 1'b1);
      chk($sformatf("v%0d_eq", i),    32'(c_eq),  32'(vecs[i].e_eq));
      chk($sformatf("v%0d_gt", i),    32'(c_gt),  32'(vecs[i].e_gt));
      chk($sformatf("v%0d_lt", i),    32'(c_lt),  32'(vecs[i].e_lt));
      chk($sformatf("v%0d_taken", i), 32'(c_tk),  32'(vecs[i].e_tk));
      chk($sformatf("v%0d_err", i),   32'(c_err), 32'(vecs[i].e_err));
      chk($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].e_lat));
      chk($sformatf("v%0d_slc_a_seq", i), 32'(seq_a), 32'(vecs[i].e_sa));
      chk($sformatf("v%0d_slc_b_seq", i), 32'(seq_b), 32'(vecs[i].e_sb));
    end

    // Backpressure with a reserved code, plus a request queued behind it
    issue(1'b0, 16'h0005, 16'h0003, 3'b010, 1'b0);
    chk("bp_latency", 32'(lat), 32'd5);
    rs1       = 16'h0001;
    rs2       = 16'h0002;
    func      = 3'b100;
    req_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk($sformatf("bp%0d_resp_valid", k), 32'(c_resp_valid), 32'd1);
      chk($sformatf("bp%0d_flags", k), 32'({c_eq, c_gt, c_lt, c_tk, c_err}), 32'b01001);
      chk($sformatf("bp%0d_req_ready", k), 32'(c_req_ready), 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_idle_ready", 32'(c_req_ready), 32'd1);
    chk("bp_idle_resp_valid", 32'(c_resp_valid), 32'd0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("bp_pending_accepted", 32'(c_req_ready), 32'd0);
    wait_resp();
    chk("bp_pending_flags", 32'({c_eq, c_gt, c_lt, c_tk, c_err}), 32'b00110);
    chk("bp_pending_latency", 32'(lat), 32'd5);

    // Reset in the second RUN cycle discards the operation
    sel        = 1'b0;
    resp_ready = 1'b1;
    wait_ready();
    rs1       = 16'h1234;
    rs2       = 16'h1234;
    func      = 3'b000;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    chk("mid_run_busy", 32'(c_req_ready), 32'd0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("rst_mid_req_ready", 32'(c_req_ready), 32'd1);
    chk("rst_mid_resp_valid", 32'(c_resp_valid), 32'd0);
    begin
      logic seen;
      seen = 1'b0;
      for (int k = 0; k < 6; k++) begin
        @(posedge clk); #1;
        seen = seen | c_resp_valid;
      end
      chk("rst_mid_no_resp", 32'(seen), 32'd0);
    end
    issue(1'b0, 16'hFFFF, 16'hFFFE, 3'b100, 1'b1);
    chk("post_rst_flags", 32'({c_eq, c_gt, c_lt, c_tk, c_err}), 32'b01000);
    chk("post_rst_latency", 32'(lat), 32'd5);

    @(posedge clk); #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
